// File: rtl/sdf_feedback_buf_pkg.sv
// Shared constants and helpers for the SDF feedback buffer stage.
// Widths, default stage geometry and the downstream butterfly pipeline delays.
package sdf_feedback_buf_pkg;

  localparam int LOGQ = 64;

  // Butterfly pipeline breakdown; the stage must know the total round-trip delay.
  localparam int DELAY_ADD = 1;
  localparam int DELAY_MUL = 4;
  localparam int DELAY_RED = 2;

  localparam int DEFAULT_DEPTH   = 8;
  localparam int DEFAULT_BTF_LAT = DELAY_ADD + DELAY_MUL + DELAY_RED;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdf_feedback_buf_if.sv
// Stream-in / butterfly / stream-out signal bundle of one SDF stage.
// The slave modport is the buffer itself; master is the surrounding datapath.
interface sdf_feedback_buf_if #(
  parameter int LOGQ  = sdf_feedback_buf_pkg::LOGQ,
  parameter int DEPTH = sdf_feedback_buf_pkg::DEFAULT_DEPTH
);
  localparam int AW = sdf_feedback_buf_pkg::clog2(DEPTH);

  logic            in_valid;
  logic [LOGQ-1:0] in_data;
  logic [LOGQ-1:0] btf_in_a;
  logic [LOGQ-1:0] btf_in_b;
  logic            btf_in_valid;
  logic [AW-1:0]   btf_w_addr;
  logic [LOGQ-1:0] btf_out_a;
  logic [LOGQ-1:0] btf_out_b;
  logic            out_valid;
  logic [LOGQ-1:0] out_data;

  modport master (
    output in_valid, in_data, btf_out_a, btf_out_b,
    input  btf_in_a, btf_in_b, btf_in_valid, btf_w_addr, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, btf_out_a, btf_out_b,
    output btf_in_a, btf_in_b, btf_in_valid, btf_w_addr, out_valid, out_data
  );

endinterface

// File: rtl/sdf_feedback_buf_shiftreg.sv
// Fixed-length delay line of DEPTH registers, WIDTH bits wide.
// Cleared by reset so no stale tokens survive a restart.
module sdf_feedback_buf_shiftreg #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/sdf_feedback_buf.sv
// Single-path delay feedback stage: pairs x[k] with x[k+D] for the butterfly,
// then reorders its results into a0..a(D-1), b0..b(D-1) on the output stream.
module sdf_feedback_buf
  import sdf_feedback_buf_pkg::clog2;
#(
  parameter int LOGQ    = sdf_feedback_buf_pkg::LOGQ,
  parameter int DEPTH   = sdf_feedback_buf_pkg::DEFAULT_DEPTH,
  parameter int BTF_LAT = sdf_feedback_buf_pkg::DEFAULT_BTF_LAT,
  parameter int STAGE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  sdf_feedback_buf_if.slave bus
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [AW:0]     in_cnt;
  logic [AW-1:0]   res_cnt;
  logic [AW-1:0]   drain_cnt;
  logic            drain_active;
  logic            ret_valid;
  logic            second_half;
  logic [AW-1:0]   pair_idx;

  logic [LOGQ-1:0] pair_mem [DEPTH];
  logic [LOGQ-1:0] b_mem    [DEPTH];

  // in_cnt spans exactly 2D, so its MSB marks the second half and the low bits index the pair.
  assign second_half = in_cnt[AW];
  assign pair_idx    = in_cnt[AW-1:0];

  always_ff @(posedge clk) begin
    if (bus.in_valid && !second_half) begin
      pair_mem[pair_idx] <= bus.in_data;
    end
    if (ret_valid) begin
      b_mem[res_cnt] <= bus.btf_out_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt           <= '0;
      bus.btf_in_valid <= 1'b0;
      bus.btf_in_a     <= '0;
      bus.btf_in_b     <= '0;
      bus.btf_w_addr   <= '0;
    end else begin
      bus.btf_in_valid <= 1'b0;
      if (bus.in_valid) begin
        in_cnt <= in_cnt + (AW+1)'(1);
        if (second_half) begin
          bus.btf_in_a     <= pair_mem[pair_idx];
          bus.btf_in_b     <= bus.in_data;
          bus.btf_w_addr   <= pair_idx;
          bus.btf_in_valid <= 1'b1;
        end
      end
    end
  end

  sdf_feedback_buf_shiftreg #(
    .DEPTH (BTF_LAT),
    .WIDTH (1)
  ) u_valid_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.btf_in_valid),
    .dout (ret_valid)
  );

  // The a-results and the b-drain never overlap, so drain simply takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt       <= '0;
      drain_cnt     <= '0;
      drain_active  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      bus.out_valid <= ret_valid | drain_active;
      if (drain_active) begin
        bus.out_data <= b_mem[drain_cnt];
        drain_cnt    <= drain_cnt + AW'(1);
        if (drain_cnt == LAST_IDX) begin
          drain_active <= 1'b0;
        end
      end else if (ret_valid) begin
        bus.out_data <= bus.btf_out_a;
      end
      if (ret_valid) begin
        res_cnt <= res_cnt + AW'(1);
        if (res_cnt == LAST_IDX) begin
          drain_active <= 1'b1;
          drain_cnt    <= '0;
        end
      end
    end
  end

  a_no_ret_during_drain: assert property (@(posedge clk) disable iff (rst)
    !(ret_valid && drain_active))
    else $error("stage %0d: butterfly result arrived during b drain", STAGE);

endmodule

// File: tb/tb_sdf_feedback_buf.sv
// Directed bench for sdf_feedback_buf with D=4, a 7-cycle stub butterfly and a frame-level model.
module tb_sdf_feedback_buf;

  localparam int D   = 4;
  localparam int LAT = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdf_feedback_buf_if #(.LOGQ(64), .DEPTH(D)) bus ();

  sdf_feedback_buf #(
    .LOGQ    (64),
    .DEPTH   (D),
    .BTF_LAT (LAT),
    .STAGE   (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stub butterfly: a = x + y, b = y - x, fixed LAT-cycle pipeline.
  logic [63:0] sa [LAT];
  logic [63:0] sb [LAT];
  always @(posedge clk) begin
    sa[0] <= bus.btf_in_a + bus.btf_in_b;
    sb[0] <= bus.btf_in_b - bus.btf_in_a;
    for (int i = 1; i < LAT; i++) begin
      sa[i] <= sa[i-1];
      sb[i] <= sb[i-1];
    end
  end
  assign bus.btf_out_a = sa[LAT-1];
  assign bus.btf_out_b = sb[LAT-1];

  int checks   = 0;
  int failures = 0;
  int e        = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (edge %0d)", name, act, req, e);
    end
  endtask

  typedef struct { int e; logic [63:0] a; logic [63:0] b; int w; } pair_t;
  typedef struct { int e; logic [63:0] v; } out_t;

  logic [63:0] frame [$];
  pair_t       q_pair [$];
  out_t        q_out [$];
  logic [63:0] last_a, last_b;
  int          last_w;
  int          k;
  logic        pv, ov;

  int          accept_e [$];
  int          pv_e [$];
  int          out_e [$];
  logic [63:0] obs [$];
  logic [63:0] lit [$];

  // Model: collect a frame of 2D inputs, derive each expected pair and output with its cycle.
  always @(posedge clk) begin
    if (rst) begin
      frame.delete();
      q_pair.delete();
      q_out.delete();
      last_a = '0;
      last_b = '0;
      last_w = 0;
    end else if (bus.in_valid) begin
      accept_e.push_back(e);
      frame.push_back(bus.in_data);
      if (frame.size() > D) begin
        k = frame.size() - 1 - D;
        q_pair.push_back('{e, frame[k], bus.in_data, k});
        q_out.push_back('{e + LAT + 1, frame[k] + bus.in_data});
      end
      if (frame.size() == 2 * D) begin
        for (int j = 0; j < D; j++) begin
          q_out.push_back('{e + LAT + 2 + j, frame[D+j] - frame[j]});
        end
        frame.delete();
      end
    end
    #1;
    pv = (q_pair.size() > 0) && (q_pair[0].e == e);
    chk("btf_in_valid", bus.btf_in_valid, pv);
    if (pv) begin
      last_a = q_pair[0].a;
      last_b = q_pair[0].b;
      last_w = q_pair[0].w;
      void'(q_pair.pop_front());
    end
    if (bus.btf_in_valid) pv_e.push_back(e);
    chk("btf_in_a", bus.btf_in_a, last_a);
    chk("btf_in_b", bus.btf_in_b, last_b);
    chk("btf_w_addr", bus.btf_w_addr, last_w);
    ov = (q_out.size() > 0) && (q_out[0].e == e);
    chk("out_valid", bus.out_valid, ov);
    if (ov) begin
      chk("out_data", bus.out_data, q_out[0].v);
      void'(q_out.pop_front());
    end
    if (bus.out_valid) begin
      obs.push_back(bus.out_data);
      out_e.push_back(e);
    end
    e++;
  end

  task automatic send(input logic [63:0] v);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic clear_logs();
    accept_e.delete();
    pv_e.delete();
    out_e.delete();
    obs.delete();
  endtask

  task automatic check_seq(input string name);
    chk({name, "_count"}, obs.size(), lit.size());
    for (int i = 0; i < lit.size() && i < obs.size(); i++) begin
      chk($sformatf("%s_val%0d", name, i), obs[i], lit[i]);
    end
    chk({name, "_drained"}, q_out.size(), 0);
  endtask

  task automatic check_reset_state(input string name);
    #1;
    chk({name, "_out_valid"}, bus.out_valid, 0);
    chk({name, "_btf_in_valid"}, bus.btf_in_valid, 0);
    chk({name, "_out_data"}, bus.out_data, 0);
    chk({name, "_btf_in_a"}, bus.btf_in_a, 0);
    chk({name, "_btf_w_addr"}, bus.btf_w_addr, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single frame, consecutive inputs.
    clear_logs();
    for (int v = 1; v <= 8; v++) send(64'(v));
    idle(20);
    lit = {64'd6, 64'd8, 64'd10, 64'd12, 64'd4, 64'd4, 64'd4, 64'd4};
    check_seq("frame1");
    if (accept_e.size() >= 5 && pv_e.size() >= 1 && out_e.size() >= 1) begin
      chk("lat_btf_in_valid", 64'(pv_e[0] - accept_e[4]), 0);
      chk("lat_first_out", 64'(out_e[0] - accept_e[4]), 8);
    end else begin
      chk("lat_events_present", 0, 1);
    end

    // Two frames back to back.
    clear_logs();
    for (int v = 1; v <= 8; v++) send(64'(v));
    for (int v = 11; v <= 18; v++) send(64'(v));
    idle(20);
    lit = {64'd6, 64'd8, 64'd10, 64'd12, 64'd4, 64'd4, 64'd4, 64'd4,
           64'd26, 64'd28, 64'd30, 64'd32, 64'd4, 64'd4, 64'd4, 64'd4};
    check_seq("b2b");

    // in_valid low on every other cycle.
    clear_logs();
    for (int v = 1; v <= 8; v++) begin
      send(64'(v));
      idle(1);
    end
    idle(20);
    lit = {64'd6, 64'd8, 64'd10, 64'd12, 64'd4, 64'd4, 64'd4, 64'd4};
    check_seq("gaps");
    if (out_e.size() >= 8) begin
      chk("gaps_a_spacing", 64'(out_e[1] - out_e[0]), 2);
      chk("gaps_b_after_a", 64'(out_e[4] - out_e[3]), 1);
      chk("gaps_b_contig", 64'(out_e[7] - out_e[4]), 3);
    end else begin
      chk("gaps_events_present", 0, 1);
    end

    // Reset after 6 inputs, then a clean frame.
    clear_logs();
    for (int v = 1; v <= 6; v++) send(64'(v));
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    check_reset_state("midreset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_logs();
    for (int v = 1; v <= 8; v++) send(64'(v));
    idle(20);
    lit = {64'd6, 64'd8, 64'd10, 64'd12, 64'd4, 64'd4, 64'd4, 64'd4};
    check_seq("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
